// File: rtl/ntb_dma_pkg.sv
// ntb_dma_pkg: shared definitions for the nametable block-transfer engine.
// Register indices, ctrl bit positions and the FSM state encoding live here
// so the engine, any address decoder and the bench agree on one copy.
package ntb_dma_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] REG_DST_LO = 3'd0;
    localparam logic [2:0] REG_DST_HI = 3'd1;
    localparam logic [2:0] REG_SRC_LO = 3'd2;
    localparam logic [2:0] REG_SRC_HI = 3'd3;
    localparam logic [2:0] REG_LEN_LO = 3'd4;
    localparam logic [2:0] REG_LEN_HI = 3'd5;
    localparam logic [2:0] REG_ATTR   = 3'd6;
    localparam logic [2:0] REG_CTRL   = 3'd7;

    localparam int CTRL_START   = 0;
    localparam int CTRL_FILL    = 1;
    localparam int CTRL_IRQ_CLR = 6;
    localparam int CTRL_ABORT   = 7;

    // Byte count register width; a programmed value of 0 means 4096 bytes.
    localparam int LEN_W = 12;

    // Rows 0x3C0..0x3FF of each 1 KB nametable hold attribute bytes.
    function automatic logic atr_row(input logic [3:0] row);
        return row == 4'hF;
    endfunction

endpackage

// File: rtl/ntb_dma_if.sv
// ntb_dma_if: register port, work-RAM source port and VRAM write port of
// the transfer engine, bundled for connection between engine and system.
//
// Source handshake: src_req is raised by the engine with src_addr stable and
// stays high until the cycle in which the memory pulses src_ack for one cycle;
// src_dat is valid in that same cycle, and the request drops the cycle after.
interface ntb_dma_if #(
    parameter int DST_W = 11,
    parameter int SRC_W = 12
);
    logic             reg_we;
    logic [2:0]       reg_addr;
    logic [7:0]       reg_di;
    logic [7:0]       reg_do;
    logic             src_req;
    logic [SRC_W-1:0] src_addr;
    logic             src_ack;
    logic [7:0]       src_dat;
    logic             vram_we;
    logic [DST_W-1:0] vram_addr;
    logic [7:0]       vram_dat;
    logic [3:0]       vram_atr;
    logic             busy;
    logic             irq;

    // Engine side.
    modport master (
        input  reg_we, reg_addr, reg_di, src_ack, src_dat,
        output reg_do, src_req, src_addr, vram_we, vram_addr, vram_dat,
               vram_atr, busy, irq
    );

    // System side (CPU registers, work RAM, VRAM unit).
    modport slave (
        output reg_we, reg_addr, reg_di, src_ack, src_dat,
        input  reg_do, src_req, src_addr, vram_we, vram_addr, vram_dat,
               vram_atr, busy, irq
    );
endinterface

// File: rtl/ntb_dma_tmo.sv
// ntb_dma_tmo: loadable down-counter with an expiry flag, used to bound the
// number of cycles the engine waits for a source acknowledge.
module ntb_dma_tmo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         sys_rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expired_o
);
    logic [W-1:0] cnt_q;

    // Reload while idle, count down while enabled, stick at zero.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired_o = (cnt_q == '0);
endmodule

// File: rtl/ntb_dma.sv
// ntb_dma: block-transfer engine filling the shadow nametable/attribute RAM
// from work RAM (copy mode) or with a repeated byte (fill mode).
// Optional build macro NTB_DMA_ATR_SKIP_EN suppresses writes into attribute
// rows (dst[9:6] == 4'b1111) while still advancing all counters.
module ntb_dma
    import ntb_dma_pkg::*;
#(
    parameter int DST_W   = 11,
    parameter int SRC_W   = 12,
    parameter int ACK_TMO = 255
) (
    input  logic      clk,
    input  logic      sys_rst,
    ntb_dma_if.master bus,
    output state_t    dbg_state_o
);
    localparam int               TMO_W    = $clog2(ACK_TMO + 1);
    // The first FETCH cycle sees the loaded value, so ACK_TMO cycles elapse
    // before the counter reaches zero.
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(ACK_TMO - 1);

    state_t             state_q, state_d;
    logic [DST_W-1:0]   dst_q, dst_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [3:0]         attr_q, attr_d;
    logic [7:0]         dat_q, dat_d;
    logic               fill_q, fill_d;
    logic               irq_q, irq_d;
    logic               err_q, err_d;

    logic               ctrl_wr, abort, start, busy;
    logic               tmo_load, tmo_en, tmo_expired, atr_skip;
    logic [15:0]        dst_x, src_x, len_x;

    assign ctrl_wr = bus.reg_we && (bus.reg_addr == REG_CTRL);
    assign abort   = ctrl_wr && bus.reg_di[CTRL_ABORT];
    // Abort in the same write wins over start.
    assign start   = ctrl_wr && bus.reg_di[CTRL_START] && !bus.reg_di[CTRL_ABORT];
    assign busy    = (state_q == S_FETCH) || (state_q == S_WRITE);

    assign tmo_load = (state_q != S_FETCH);
    assign tmo_en   = (state_q == S_FETCH);

    ntb_dma_tmo #(.W(TMO_W)) u_tmo (
        .clk        (clk),
        .sys_rst    (sys_rst),
        .load_i     (tmo_load),
        .load_val_i (TMO_LOAD),
        .en_i       (tmo_en),
        .expired_o  (tmo_expired)
    );

`ifdef NTB_DMA_ATR_SKIP_EN
    assign atr_skip = atr_row(dst_q[9:6]);
`else
    assign atr_skip = 1'b0;
`endif

    // State and working-counter registers.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            dst_q   <= '0;
            src_q   <= '0;
            len_q   <= '0;
            attr_q  <= '0;
            dat_q   <= '0;
            fill_q  <= 1'b0;
            irq_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            len_q   <= len_d;
            attr_q  <= attr_d;
            dat_q   <= dat_d;
            fill_q  <= fill_d;
            irq_q   <= irq_d;
            err_q   <= err_d;
        end
    end

    // Register writes, next-state and counter updates.
    always_comb begin
        state_d = state_q;
        dst_d   = dst_q;
        src_d   = src_q;
        len_d   = len_q;
        attr_d  = attr_q;
        dat_d   = dat_q;
        fill_d  = fill_q;
        irq_d   = irq_q;
        err_d   = err_q;

        // The programmed registers double as working counters, so they are
        // only writable while no transfer is moving them.
        if (bus.reg_we && !busy) begin
            case (bus.reg_addr)
                REG_DST_LO: dst_d[7:0]       = bus.reg_di;
                REG_DST_HI: dst_d[DST_W-1:8] = bus.reg_di[DST_W-9:0];
                REG_SRC_LO: src_d[7:0]       = bus.reg_di;
                REG_SRC_HI: src_d[SRC_W-1:8] = bus.reg_di[SRC_W-9:0];
                REG_LEN_LO: len_d[7:0]       = bus.reg_di;
                REG_LEN_HI: len_d[11:8]      = bus.reg_di[3:0];
                REG_ATTR:   attr_d           = bus.reg_di[3:0];
                default: ;
            endcase
        end

        if (ctrl_wr && bus.reg_di[CTRL_IRQ_CLR]) begin
            irq_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    fill_d  = bus.reg_di[CTRL_FILL];
                    state_d = bus.reg_di[CTRL_FILL] ? S_WRITE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (bus.src_ack) begin
                    dat_d   = bus.src_dat;
                    src_d   = src_q + SRC_W'(1);
                    state_d = S_WRITE;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    irq_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WRITE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    dst_d = dst_q + DST_W'(1);
                    len_d = len_q - LEN_W'(1);
                    if (len_q == LEN_W'(1)) begin
                        irq_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = fill_q ? S_WRITE : S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Register read-back mux over the live counters.
    always_comb begin
        dst_x = 16'(dst_q);
        src_x = 16'(src_q);
        len_x = 16'(len_q);
        case (bus.reg_addr)
            REG_DST_LO: bus.reg_do = dst_x[7:0];
            REG_DST_HI: bus.reg_do = dst_x[15:8];
            REG_SRC_LO: bus.reg_do = src_x[7:0];
            REG_SRC_HI: bus.reg_do = src_x[15:8];
            REG_LEN_LO: bus.reg_do = len_x[7:0];
            REG_LEN_HI: bus.reg_do = len_x[15:8];
            REG_ATTR:   bus.reg_do = {4'b0000, attr_q};
            default:    bus.reg_do = {busy, irq_q, err_q, 4'b0000, fill_q};
        endcase
    end

    assign bus.src_req   = (state_q == S_FETCH);
    assign bus.src_addr  = src_q;
    // An abort landing on a WRITE cycle cancels that byte as well.
    assign bus.vram_we   = (state_q == S_WRITE) && !abort && !atr_skip;
    assign bus.vram_addr = dst_q;
    assign bus.vram_dat  = fill_q ? src_q[7:0] : dat_q;
    assign bus.vram_atr  = attr_q;
    assign bus.busy      = busy;
    assign bus.irq       = irq_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_ntb_dma.sv
// tb_ntb_dma: directed and randomized checks of the nametable transfer engine
// against a byte-list model of the transfer rules.
module tb_ntb_dma;
    import ntb_dma_pkg::*;

    logic   clk = 1'b0;
    logic   sys_rst;
    state_t dbg_state;

    ntb_dma_if #(.DST_W(11), .SRC_W(12)) bus ();

    ntb_dma #(.DST_W(11), .SRC_W(12), .ACK_TMO(255)) dut (
        .clk         (clk),
        .sys_rst     (sys_rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_writes = 0;
    logic [22:0] exp_q[$];
    bit          ack_en   = 1'b1;
    int          max_wait = 0;
    logic [10:0] exp_dst_f;
    logic [11:0] exp_src_f;
    int          exp_nwr;
    int          wr_base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [11:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic bit skipped(input logic [10:0] a);
`ifdef NTB_DMA_ATR_SKIP_EN
        return a[9:6] == 4'hF;
`else
        return (a == 11'h7FF) && (a != 11'h7FF);
`endif
    endfunction

    // Driver: caller is at a falling edge; returns at the next falling edge.
    task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
        bus.reg_we   = 1'b1;
        bus.reg_addr = a;
        bus.reg_di   = d;
        @(negedge clk);
        bus.reg_we   = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [7:0] d);
        bus.reg_addr = a;
        #1;
        d = bus.reg_do;
    endtask

    task automatic read_ctr(output logic [10:0] dst, output logic [11:0] src, output logic [11:0] len);
        logic [7:0] lo, hi;
        reg_read(REG_DST_LO, lo); reg_read(REG_DST_HI, hi); dst = {hi[2:0], lo};
        reg_read(REG_SRC_LO, lo); reg_read(REG_SRC_HI, hi); src = {hi[3:0], lo};
        reg_read(REG_LEN_LO, lo); reg_read(REG_LEN_HI, hi); len = {hi[3:0], lo};
    endtask

    // Program registers, build expected write list, issue start.
    task automatic start_xfer(input logic [10:0] dst, input logic [11:0] src, input logic [11:0] len,
                              input logic [3:0] attr, input logic fill);
        int          n;
        logic [10:0] a;
        n = (len == 12'd0) ? 4096 : int'(len);
        exp_nwr = 0;
        for (int i = 0; i < n; i++) begin
            a = 11'(int'(dst) + i);
            if (!skipped(a)) begin
                exp_q.push_back({a, fill ? src[7:0] : mem_byte(12'(int'(src) + i)), attr});
                exp_nwr++;
            end
        end
        exp_dst_f = 11'(int'(dst) + n);
        exp_src_f = fill ? src : 12'(int'(src) + n);
        reg_write(REG_DST_LO, dst[7:0]);
        reg_write(REG_DST_HI, {5'b0, dst[10:8]});
        reg_write(REG_SRC_LO, src[7:0]);
        reg_write(REG_SRC_HI, {4'b0, src[11:8]});
        reg_write(REG_LEN_LO, len[7:0]);
        reg_write(REG_LEN_HI, {4'b0, len[11:8]});
        reg_write(REG_ATTR, {4'b0, attr});
        wr_base = n_writes;
        reg_write(REG_CTRL, {6'b0, fill, 1'b1});
    endtask

    // Wait for completion and check end state; exp_cycles < 0 skips timing.
    task automatic finish_xfer(input string tag, input logic fill, input int budget, input int exp_cycles);
        int          cycles;
        logic [7:0]  rd;
        logic [10:0] dst_r;
        logic [11:0] src_r, len_r;
        check({tag, "_busy_after_start"}, bus.busy, 1);
        cycles = 0;
        while (bus.busy && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, "_done_in_budget"}, bus.busy, 0);
        if (exp_cycles >= 0) check({tag, "_cycles"}, cycles, exp_cycles);
        check({tag, "_irq"}, bus.irq, 1);
        reg_read(REG_CTRL, rd);
        check({tag, "_ctrl_read"}, rd, {7'b0100000, fill});
        @(negedge clk);
        check({tag, "_all_writes_seen"}, exp_q.size(), 0);
        check({tag, "_write_count"}, n_writes - wr_base, exp_nwr);
        read_ctr(dst_r, src_r, len_r);
        check({tag, "_final_dst"}, dst_r, exp_dst_f);
        check({tag, "_final_src"}, src_r, exp_src_f);
        check({tag, "_final_len"}, len_r, 0);
        @(negedge clk);
    endtask

    // Scoreboard: every VRAM write must match the head of the expected list.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.vram_we) begin
                n_writes++;
                n_assert++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_vram_we: observed write at %0h, expected none", bus.vram_addr);
                end
                if (exp_q.size() != 0)
                    check("vram_write", {bus.vram_addr, bus.vram_dat, bus.vram_atr}, exp_q.pop_front());
            end
        end
    end

    // Work-RAM responder: byte at address a is a ^ 0x5A, random wait states.
    initial begin
        int wcnt;
        int cur_wait;
        wcnt = 0;
        cur_wait = 0;
        bus.src_ack = 1'b0;
        bus.src_dat = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.src_ack) begin
                bus.src_ack = 1'b0;
            end else if (bus.src_req && ack_en) begin
                if (wcnt >= cur_wait) begin
                    bus.src_ack = 1'b1;
                    bus.src_dat = mem_byte(bus.src_addr);
                    wcnt = 0;
                    cur_wait = int'($urandom_range(max_wait, 0));
                end else begin
                    wcnt++;
                end
            end
        end
    end

    initial begin
        logic [7:0]  rd;
        logic [10:0] dst_r;
        logic [11:0] src_r, len_r;
        int          k, guard, w0, cycles;
        logic [10:0] rdst;
        logic [11:0] rsrc, rlen;

        bus.reg_we = 1'b0;
        bus.reg_addr = 3'd0;
        bus.reg_di = 8'h00;
        sys_rst = 1'b1;
        repeat (3) @(negedge clk);
        sys_rst = 1'b0;
        @(negedge clk);

        // Reset state.
        for (int i = 0; i < 8; i++) begin
            reg_read(3'(i), rd);
            check($sformatf("reset_reg%0d", i), rd, 0);
        end
        check("reset_src_req", bus.src_req, 0);
        check("reset_vram_we", bus.vram_we, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_irq", bus.irq, 0);
        check("reset_state", dbg_state, S_IDLE);
        @(negedge clk);

        // Copy across the 0x3FF->0x400 boundary, zero-wait source.
        max_wait = 0;
        start_xfer(11'h3F0, 12'h010, 12'h020, 4'h5, 1'b0);
        finish_xfer("copy0", 1'b0, 200, 64);

        // Full 4096-byte fill with irq still pending from the previous run.
        start_xfer(11'h7F0, 12'h024, 12'h000, 4'h9, 1'b1);
        check("fill_irq_held", bus.irq, 1);
        finish_xfer("fill4k", 1'b1, 5000, 4096);

        // Source never acknowledges: timeout sets err and irq, no writes.
        reg_write(REG_CTRL, 8'h40);
        ack_en = 1'b0;
        start_xfer(11'h020, 12'h300, 12'h004, 4'h1, 1'b0);
        exp_q.delete();
        cycles = 0;
        while (bus.busy && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
        check("tmo_cycles", cycles, 255);
        check("tmo_irq", bus.irq, 1);
        reg_read(REG_CTRL, rd);
        check("tmo_ctrl_read", rd, 8'h60);
        @(negedge clk);
        check("tmo_no_writes", n_writes - wr_base, 0);
        reg_write(REG_CTRL, 8'h40);
        reg_read(REG_CTRL, rd);
        check("tmo_irq_cleared_err_kept", rd, 8'h20);
        @(negedge clk);
        ack_en = 1'b1;

        // Randomized copies with wait states; start also clears err.
        max_wait = 3;
        for (int t = 0; t < 3; t++) begin
            rdst = 11'($urandom);
            rsrc = 12'($urandom);
            rlen = 12'($urandom_range(40, 1));
            start_xfer(rdst, rsrc, rlen, 4'($urandom), 1'b0);
            finish_xfer($sformatf("rcopy%0d", t), 1'b0, 400, -1);
        end

        // Writes to regs and start are ignored while busy.
        max_wait = 2;
        start_xfer(11'h155, 12'hABC, 12'h008, 4'hC, 1'b0);
        repeat (3) @(negedge clk);
        reg_write(REG_DST_LO, 8'hFF);
        reg_write(REG_CTRL, 8'h01);
        finish_xfer("lockout", 1'b0, 200, -1);
        reg_write(REG_CTRL, 8'h40);
        reg_read(REG_CTRL, rd);
        check("irq_clear", rd, 8'h00);
        check("irq_clear_pin", bus.irq, 0);
        @(negedge clk);

        // Abort after the fifth byte of a 16-byte copy.
        max_wait = 0;
        start_xfer(11'h100, 12'h200, 12'h010, 4'h3, 1'b0);
        k = 0;
        guard = 0;
        while (k < 5 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (bus.vram_we) k++;
        end
        check("abort_reached_byte5", k, 5);
        @(negedge clk);
        reg_write(REG_CTRL, 8'h80);
        check("abort_busy", bus.busy, 0);
        check("abort_src_req", bus.src_req, 0);
        check("abort_vram_we", bus.vram_we, 0);
        check("abort_irq", bus.irq, 0);
        exp_q.delete();
        w0 = n_writes;
        repeat (10) @(negedge clk);
        check("abort_no_more_writes", n_writes - w0, 0);
        read_ctr(dst_r, src_r, len_r);
        check("abort_len", len_r, 11);
        check("abort_dst", dst_r, 11'h105);
        check("abort_src", src_r, 12'h205);
        reg_read(REG_CTRL, rd);
        check("abort_ctrl_read", rd, 8'h00);
        @(negedge clk);

        // Fill across the attribute rows of nametable 0.
        start_xfer(11'h3B8, 12'h077, 12'h010, 4'h6, 1'b1);
        finish_xfer("atr_fill", 1'b1, 100, 16);
        reg_write(REG_CTRL, 8'h40);

        // Randomized short fill.
        start_xfer(11'($urandom), 12'($urandom), 12'($urandom_range(64, 1)), 4'($urandom), 1'b1);
        finish_xfer("rfill", 1'b1, 100, -1);

        // Reset in the middle of a transfer.
        start_xfer(11'h010, 12'h0AA, 12'd100, 4'h2, 1'b1);
        repeat (10) @(negedge clk);
        sys_rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        check("midrst_busy", bus.busy, 0);
        check("midrst_vram_we", bus.vram_we, 0);
        check("midrst_src_req", bus.src_req, 0);
        check("midrst_irq", bus.irq, 0);
        read_ctr(dst_r, src_r, len_r);
        check("midrst_dst", dst_r, 0);
        check("midrst_len", len_r, 0);
        @(negedge clk);
        sys_rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
